// File: rtl/prio_enc_pkg.sv
// Shared constants, index-width helper and arbitration-mode decode for the priority encoder.
// Latency: none (package only).
// Backpressure: not applicable.
package prio_enc_pkg;

    // Default number of request lines.
    localparam int DEF_N = 8;

    // Index width for n request lines; never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Decode of the rr_en pin.
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational selector: highest set bit (fixed) or first set bit at/after ptr with wrap (round-robin).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter  int N = DEF_N,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    input  arb_mode_t    mode,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic [W-1:0]   fix_idx;
    logic [W-1:0]   rr_idx;

    // Mask of bit positions at or above the round-robin pointer.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
    end

    // Lower half holds the preferred bits (>= ptr); upper half is the full vector
    // and supplies the wrapped-around candidates below ptr.
    assign dbl = {vec, vec & hi_mask};

    // Fixed priority: highest set index wins, so later iterations override.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                fix_idx = W'(i);
            end
        end
    end

    // Round-robin: lowest set bit of the double-width vector, folded back into 0..N-1.
    always_comb begin
        rr_idx = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl[j]) begin
                rr_idx = (j >= N) ? W'(j - N) : W'(j);
            end
        end
    end

    assign found = |vec;
    assign idx   = (mode == ARB_RR) ? rr_idx : fix_idx;

endmodule

// File: rtl/prio_encoder_q.sv
// Registered N-to-log2(N) priority encoder with sticky request capture and valid/ready output.
// Latency: request sampled at edge E is pending after E; earliest out_valid after E+1; one issue per cycle.
// Backpressure: with out_valid=1 and out_ready=0 the output holds and new requests keep accumulating in pending.
module prio_encoder_q
    import prio_enc_pkg::*;
#(
    parameter  int N       = DEF_N,
    parameter  int RST_PTR = 0,
    localparam int W       = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         rr_en,
    input  logic         flush,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         none_pending
);

    logic [W-1:0] ptr;
    logic [W-1:0] pick_idx;
    logic         pick_found;
    logic         free;
    logic         issue;
    logic [W-1:0] ptr_nxt;
    logic [N-1:0] issue_clr;
    logic [N-1:0] pending_nxt;

    prio_pick #(
        .N (N)
    ) u_pick (
        .vec   (pending),
        .ptr   (ptr),
        .mode  (arb_mode_t'(rr_en)),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Output slot can take a new index when empty or being drained this edge.
    assign free  = ~out_valid | out_ready;
    // Flush suppresses issue even if the slot is free.
    assign issue = free & pick_found & ~flush;

    // Wrap against N-1 so non-power-of-two N never produces an out-of-range pointer.
    assign ptr_nxt = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);

    // One-hot clear of the issued bit.
    always_comb begin
        issue_clr = '0;
        for (int i = 0; i < N; i++) begin
            issue_clr[i] = issue && (pick_idx == W'(i));
        end
    end

    // Set wins over clear; flush keeps only requests presented in the flush cycle.
    assign pending_nxt = flush ? req_in : ((pending & ~issue_clr) | req_in);

    assign none_pending = (pending == '0) & ~out_valid;

    // Sticky pending requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Output slot valid: cleared by flush, refilled (or emptied) whenever free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (free) begin
            out_valid <= pick_found;
        end
    end

    // Issued index and round-robin pointer move only on issue, never on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx <= '0;
            ptr     <= W'(RST_PTR);
        end else if (issue) begin
            out_idx <= pick_idx;
            ptr     <= ptr_nxt;
        end
    end

endmodule
